// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : npc_pkg
// Purpose  : Shared encodings for the next-PC select interface: NPC_ctrl
//            codes, branch/jump type codes, resolution FSM states and small
//            helpers that classify an instruction's control-transfer type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package npc_pkg;

   // Next-PC select codes consumed by the fetch-stage PC multiplexer.
   typedef enum logic [1:0] {
      NPC_PC4  = 2'b00,
      NPC_BR   = 2'b01,
      NPC_JR   = 2'b10,
      NPC_JJAL = 2'b11
   } npc_ctrl_e;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BLEZ = 3'd3,
      BR_BGTZ = 3'd4,
      BR_BLTZ = 3'd5,
      BR_BGEZ = 3'd6,
      BR_RSVD = 3'd7
   } br_type_e;

   typedef enum logic [1:0] {
      J_NONE = 2'd0,
      J_JJAL = 2'd1,
      J_JR   = 2'd2,
      J_RSVD = 2'd3
   } j_type_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } npc_state_e;

   function automatic logic f_is_jump(input j_type_e j);
      return (j == J_JJAL) || (j == J_JR);
   endfunction

   function automatic logic f_is_branch(input br_type_e b);
      return (b != BR_NONE) && (b != BR_RSVD);
   endfunction

   // A jump overrides any branch code, so a j/jal needs no operands even if
   // Br_type happens to be nonzero.
   function automatic logic f_need_rs(input j_type_e j, input br_type_e b);
      if (j == J_JR)
         return 1'b1;
      else if (f_is_jump(j))
         return 1'b0;
      else
         return f_is_branch(b);
   endfunction

   function automatic logic f_need_rt(input j_type_e j, input br_type_e b);
      return !f_is_jump(j) && ((b == BR_BEQ) || (b == BR_BNE));
   endfunction

endpackage : npc_pkg
`default_nettype wire

// File: rtl/npc_target_calc.sv
`default_nettype none
// ============================================================================
// Module   : npc_target_calc
// Purpose  : Combinational target and condition evaluation for decode-stage
//            control transfers.
// Ports    : i_pc_id    [31:0] PC of the decode-stage instruction
//            i_imm16    [15:0] branch offset field
//            i_index26  [25:0] jump index field
//            i_rs_val   [31:0] forwarded RS operand
//            i_rt_val   [31:0] forwarded RT operand
//            i_br_type  [2:0]  branch type code
//            i_j_type   [1:0]  jump type code
//            o_br       [31:0] branch target
//            o_jr       [31:0] register-jump target
//            o_j_jal    [31:0] absolute-jump target
//            o_taken           redirect taken (jumps always, branches on cond)
// Revision : 1.0 - initial release
// ============================================================================
module npc_target_calc
   import npc_pkg::*;
(
   input  logic [31:0] i_pc_id,
   input  logic [15:0] i_imm16,
   input  logic [25:0] i_index26,
   input  logic [31:0] i_rs_val,
   input  logic [31:0] i_rt_val,
   input  logic [2:0]  i_br_type,
   input  logic [1:0]  i_j_type,
   output logic [31:0] o_br,
   output logic [31:0] o_jr,
   output logic [31:0] o_j_jal,
   output logic        o_taken
);

   logic [31:0] w_pc4;
   logic        w_rs_neg;
   logic        w_rs_zero;
   logic        w_rs_eq_rt;
   logic        w_br_cond;
   br_type_e    w_br;
   j_type_e     w_j;

   assign w_br       = br_type_e'(i_br_type);
   assign w_j        = j_type_e'(i_j_type);
   assign w_pc4      = i_pc_id + 32'd4;
   assign w_rs_neg   = i_rs_val[31];
   assign w_rs_zero  = (i_rs_val == 32'd0);
   assign w_rs_eq_rt = (i_rs_val == i_rt_val);

   assign o_br    = w_pc4 + {{14{i_imm16[15]}}, i_imm16, 2'b00};
   assign o_jr    = i_rs_val;
   assign o_j_jal = {w_pc4[31:28], i_index26, 2'b00};

   always_comb begin
      w_br_cond = 1'b0;
      case (w_br)
         BR_BEQ:  w_br_cond = w_rs_eq_rt;
         BR_BNE:  w_br_cond = !w_rs_eq_rt;
         BR_BLEZ: w_br_cond = w_rs_neg || w_rs_zero;
         BR_BGTZ: w_br_cond = !w_rs_neg && !w_rs_zero;
         BR_BLTZ: w_br_cond = w_rs_neg;
         BR_BGEZ: w_br_cond = !w_rs_neg;
         default: w_br_cond = 1'b0;
      endcase
   end

   assign o_taken = f_is_jump(w_j) || w_br_cond;

endmodule : npc_target_calc
`default_nettype wire

// File: rtl/npc_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : npc_ctrl_gen
// Purpose  : Decode-stage control-transfer resolution. Produces the next-PC
//            select code and target buses, stalls while forwarded operands
//            are not final, and replays a resolved redirect while fetch is
//            frozen.
// Ports    : clk, reset            clock, asynchronous active-high reset
//            ID_valid              decode stage holds a real instruction
//            Br_type [2:0]         branch type code
//            J_type  [1:0]         jump type code (priority over Br_type)
//            PC_ID   [31:0]        PC of decode-stage instruction
//            Imm16   [15:0]        branch offset field
//            Index26 [25:0]        jump index field
//            RS_val, RT_val [31:0] forwarded operands
//            RS_ready, RT_ready    forwarded operands are final
//            Fetch_stall           PC register will not load this cycle
//            NPC_ctrl [1:0]        next-PC select
//            BR, JR, J_JAL [31:0]  target buses
//            Stall_req             hold IF/ID and ID/EX this cycle
//            Hold_active           a latched redirect is pending
//            Wait_timeout          sticky operand-wait watchdog flag
// Revision : 1.0 - initial release
// ============================================================================
module npc_ctrl_gen
   import npc_pkg::*;
#(
   parameter int WAIT_LIMIT = 15
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        ID_valid,
   input  logic [2:0]  Br_type,
   input  logic [1:0]  J_type,
   input  logic [31:0] PC_ID,
   input  logic [15:0] Imm16,
   input  logic [25:0] Index26,
   input  logic [31:0] RS_val,
   input  logic [31:0] RT_val,
   input  logic        RS_ready,
   input  logic        RT_ready,
   input  logic        Fetch_stall,
   output logic [1:0]  NPC_ctrl,
   output logic [31:0] BR,
   output logic [31:0] JR,
   output logic [31:0] J_JAL,
   output logic        Stall_req,
   output logic        Hold_active,
   output logic        Wait_timeout
);

   localparam int                CNT_W      = $clog2(WAIT_LIMIT + 1);
   localparam logic [CNT_W-1:0] c_WAIT_MAX = CNT_W'(WAIT_LIMIT);

   npc_state_e       r_state;
   npc_state_e       w_state_nxt;
   npc_ctrl_e        r_hold_code;
   logic [31:0]      r_hold_tgt;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_timeout;

   br_type_e    w_br;
   j_type_e     w_j;
   logic [31:0] w_br_tgt;
   logic [31:0] w_jr_tgt;
   logic [31:0] w_jjal_tgt;
   logic        w_taken;
   logic        w_is_ctrl;
   logic        w_ready;
   npc_ctrl_e   w_res_code;
   logic [31:0] w_res_tgt;
   npc_ctrl_e   w_code;
   logic        w_stall;
   logic        w_latch;
   logic        w_cnt_inc;
   logic        w_cnt_clr;
   logic        w_hold_on;

   assign w_br = br_type_e'(Br_type);
   assign w_j  = j_type_e'(J_type);

   npc_target_calc u_target_calc (
      .i_pc_id   (PC_ID),
      .i_imm16   (Imm16),
      .i_index26 (Index26),
      .i_rs_val  (RS_val),
      .i_rt_val  (RT_val),
      .i_br_type (Br_type),
      .i_j_type  (J_type),
      .o_br      (w_br_tgt),
      .o_jr      (w_jr_tgt),
      .o_j_jal   (w_jjal_tgt),
      .o_taken   (w_taken)
   );

   // Gating with reset keeps NPC_ctrl/Stall_req at their reset values for the
   // whole reset pulse, even while an instruction sits in decode.
   assign w_is_ctrl = ID_valid && !reset && (f_is_jump(w_j) || f_is_branch(w_br));
   assign w_ready   = (!f_need_rs(w_j, w_br) || RS_ready) &&
                      (!f_need_rt(w_j, w_br) || RT_ready);

   // Resolved code and the target that goes with it (what HOLD would replay).
   always_comb begin
      w_res_code = NPC_PC4;
      w_res_tgt  = 32'd0;
      if (w_taken) begin
         if (w_j == J_JJAL) begin
            w_res_code = NPC_JJAL;
            w_res_tgt  = w_jjal_tgt;
         end else if (w_j == J_JR) begin
            w_res_code = NPC_JR;
            w_res_tgt  = w_jr_tgt;
         end else begin
            w_res_code = NPC_BR;
            w_res_tgt  = w_br_tgt;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Resolution FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_code      = NPC_PC4;
      w_stall     = 1'b0;
      w_latch     = 1'b0;
      w_cnt_inc   = 1'b0;
      w_cnt_clr   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_is_ctrl) begin
               if (!w_ready) begin
                  // Operand wait wins over Fetch_stall: nothing latched yet.
                  w_stall     = 1'b1;
                  w_cnt_inc   = 1'b1;
                  w_state_nxt = ST_WAIT;
               end else begin
                  w_code    = w_res_code;
                  w_cnt_clr = 1'b1;
                  if (Fetch_stall) begin
                     w_latch     = 1'b1;
                     w_state_nxt = ST_HOLD;
                  end
               end
            end
         end
         ST_WAIT: begin
            if (!w_is_ctrl) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (!w_ready) begin
               w_stall   = 1'b1;
               w_cnt_inc = 1'b1;
            end else begin
               w_code    = w_res_code;
               w_cnt_clr = 1'b1;
               if (Fetch_stall) begin
                  w_latch     = 1'b1;
                  w_state_nxt = ST_HOLD;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_HOLD: begin
            w_code = r_hold_code;
            // A control instruction in the delay slot is not resolved here.
            w_stall = w_is_ctrl;
            if (!Fetch_stall)
               w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Hold registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold_code <= NPC_PC4;
         r_hold_tgt  <= 32'd0;
      end else if (w_latch) begin
         r_hold_code <= w_res_code;
         r_hold_tgt  <= w_res_tgt;
      end
   end

   // ------------------------------------------------------------------------
   // Operand-wait counter and sticky watchdog
   // ------------------------------------------------------------------------
   always_comb begin
      w_cnt_nxt = r_wait_cnt;
      if (w_cnt_clr)
         w_cnt_nxt = '0;
      else if (w_cnt_inc && (r_wait_cnt != c_WAIT_MAX))
         w_cnt_nxt = r_wait_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_wait_cnt <= w_cnt_nxt;
         if (w_cnt_nxt == c_WAIT_MAX)
            r_timeout <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: only the bus selected by the held code is replaced in HOLD.
   // ------------------------------------------------------------------------
   assign w_hold_on = (r_state == ST_HOLD);

   assign NPC_ctrl     = w_code;
   assign Stall_req    = w_stall;
   assign Hold_active  = w_hold_on;
   assign Wait_timeout = r_timeout;

   assign BR    = (w_hold_on && (r_hold_code == NPC_BR))   ? r_hold_tgt : w_br_tgt;
   assign JR    = (w_hold_on && (r_hold_code == NPC_JR))   ? r_hold_tgt : w_jr_tgt;
   assign J_JAL = (w_hold_on && (r_hold_code == NPC_JJAL)) ? r_hold_tgt : w_jjal_tgt;

endmodule : npc_ctrl_gen
`default_nettype wire

// File: tb/tb_npc_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_npc_ctrl_gen
// Purpose  : Directed self-checking bench for npc_ctrl_gen.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_npc_ctrl_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        ID_valid;
   logic [2:0]  Br_type;
   logic [1:0]  J_type;
   logic [31:0] PC_ID;
   logic [15:0] Imm16;
   logic [25:0] Index26;
   logic [31:0] RS_val;
   logic [31:0] RT_val;
   logic        RS_ready;
   logic        RT_ready;
   logic        Fetch_stall;
   logic [1:0]  NPC_ctrl;
   logic [31:0] BR;
   logic [31:0] JR;
   logic [31:0] J_JAL;
   logic        Stall_req;
   logic        Hold_active;
   logic        Wait_timeout;

   int n_total = 0;
   int n_bad   = 0;

   npc_ctrl_gen #(.WAIT_LIMIT(15)) dut (
      .clk          (clk),
      .reset        (reset),
      .ID_valid     (ID_valid),
      .Br_type      (Br_type),
      .J_type       (J_type),
      .PC_ID        (PC_ID),
      .Imm16        (Imm16),
      .Index26      (Index26),
      .RS_val       (RS_val),
      .RT_val       (RT_val),
      .RS_ready     (RS_ready),
      .RT_ready     (RT_ready),
      .Fetch_stall  (Fetch_stall),
      .NPC_ctrl     (NPC_ctrl),
      .BR           (BR),
      .JR           (JR),
      .J_JAL        (J_JAL),
      .Stall_req    (Stall_req),
      .Hold_active  (Hold_active),
      .Wait_timeout (Wait_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Move to 1 time unit after the next rising edge; inputs change here.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_in();
      ID_valid    = 1'b0;
      Br_type     = 3'd0;
      J_type      = 2'd0;
      RS_ready    = 1'b1;
      RT_ready    = 1'b1;
      Fetch_stall = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      PC_ID   = 32'h0;
      Imm16   = 16'h0;
      Index26 = 26'h0;
      RS_val  = 32'h0;
      RT_val  = 32'h0;
      idle_in();
      settle();
      chk_val("rst_ctrl",    32'(NPC_ctrl),     32'd0);
      chk_val("rst_stall",   32'(Stall_req),    32'd0);
      chk_val("rst_hold",    32'(Hold_active),  32'd0);
      chk_val("rst_timeout", 32'(Wait_timeout), 32'd0);
      cyc();
      cyc();
      reset = 1'b0;

      // ---------------- branch conditions ----------------
      cyc();
      ID_valid = 1'b1; Br_type = 3'd1; PC_ID = 32'h0000_3000; Imm16 = 16'h0004;
      RS_val = 32'd5; RT_val = 32'd5;
      settle();
      chk_val("beq_ctrl",  32'(NPC_ctrl),  32'd1);
      chk_val("beq_br",    BR,             32'h0000_3014);
      chk_val("beq_stall", 32'(Stall_req), 32'd0);

      cyc(); Br_type = 3'd2; settle();
      chk_val("bne_eq_ctrl", 32'(NPC_ctrl), 32'd0);

      cyc(); Br_type = 3'd1; RT_val = 32'd6; settle();
      chk_val("beq_ne_ctrl", 32'(NPC_ctrl), 32'd0);

      cyc(); Br_type = 3'd4; RS_val = 32'hFFFF_FFFF; settle();
      chk_val("bgtz_neg_ctrl", 32'(NPC_ctrl), 32'd0);

      cyc(); Br_type = 3'd5; Imm16 = 16'hFFFF; settle();
      chk_val("bltz_neg_ctrl", 32'(NPC_ctrl), 32'd1);
      chk_val("bltz_br_back",  BR,            32'h0000_3000);

      cyc(); Br_type = 3'd3; RS_val = 32'd0; settle();
      chk_val("blez_zero_ctrl", 32'(NPC_ctrl), 32'd1);

      cyc(); Br_type = 3'd6; settle();
      chk_val("bgez_zero_ctrl", 32'(NPC_ctrl), 32'd1);

      cyc(); Br_type = 3'd4; settle();
      chk_val("bgtz_zero_ctrl", 32'(NPC_ctrl), 32'd0);

      cyc(); Br_type = 3'd7; settle();
      chk_val("br7_none_ctrl", 32'(NPC_ctrl), 32'd0);

      // J_type 3 is "none", so the beq underneath still resolves.
      cyc(); Br_type = 3'd1; J_type = 2'd3; RS_val = 32'd9; RT_val = 32'd9; settle();
      chk_val("j3_beq_ctrl", 32'(NPC_ctrl), 32'd1);

      // ---------------- jr operand wait (Fetch_stall during wait) ----------
      cyc();
      Br_type = 3'd0; J_type = 2'd2; RS_ready = 1'b0; RS_val = 32'hDEAD_0000;
      Fetch_stall = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         settle();
         chk_val($sformatf("jr_wait%0d_stall", i), 32'(Stall_req), 32'd1);
         chk_val($sformatf("jr_wait%0d_ctrl", i),  32'(NPC_ctrl),  32'd0);
         chk_val($sformatf("jr_wait%0d_hold", i),  32'(Hold_active), 32'd0);
         cyc();
      end
      RS_ready = 1'b1; RS_val = 32'h0000_3100; Fetch_stall = 1'b0;
      settle();
      chk_val("jr_res_ctrl",  32'(NPC_ctrl),  32'd2);
      chk_val("jr_res_jr",    JR,             32'h0000_3100);
      chk_val("jr_res_stall", 32'(Stall_req), 32'd0);
      cyc(); idle_in(); settle();
      chk_val("jr_after_hold", 32'(Hold_active), 32'd0);

      // ---------------- jal under fetch freeze ----------------
      cyc();
      ID_valid = 1'b1; J_type = 2'd1; PC_ID = 32'h0000_3008; Index26 = 26'h000_0C40;
      Imm16 = 16'h0000; Fetch_stall = 1'b1;
      settle();
      chk_val("jal_res_ctrl", 32'(NPC_ctrl), 32'd3);
      chk_val("jal_res_tgt",  J_JAL,         32'h0000_3100);
      chk_val("jal_res_hold", 32'(Hold_active), 32'd0);
      // Delay-slot instruction now in ID; the jal inputs are gone.
      cyc();
      J_type = 2'd0; PC_ID = 32'h0000_300C; Index26 = 26'h0;
      settle();
      chk_val("jal_fz_hold",  32'(Hold_active), 32'd1);
      chk_val("jal_fz_ctrl",  32'(NPC_ctrl),    32'd3);
      chk_val("jal_fz_tgt",   J_JAL,            32'h0000_3100);
      chk_val("jal_fz_br",    BR,               32'h0000_3010);
      chk_val("jal_fz_stall", 32'(Stall_req),   32'd0);
      cyc(); Fetch_stall = 1'b0; settle();
      chk_val("jal_rel_hold", 32'(Hold_active), 32'd1);
      chk_val("jal_rel_ctrl", 32'(NPC_ctrl),    32'd3);
      chk_val("jal_rel_tgt",  J_JAL,            32'h0000_3100);
      cyc(); idle_in(); settle();
      chk_val("jal_idle_hold", 32'(Hold_active), 32'd0);
      chk_val("jal_idle_ctrl", 32'(NPC_ctrl),    32'd0);
      chk_val("jal_idle_tgt",  J_JAL,            32'h0000_0000);

      // ---------------- watchdog ----------------
      cyc();
      ID_valid = 1'b1; J_type = 2'd2; RS_ready = 1'b0;
      // Iteration i observes the flag after edge i-1 of the wait.
      for (int i = 1; i <= 16; i++) begin
         settle();
         chk_val($sformatf("wd_edge%0d", i - 1), 32'(Wait_timeout), (i >= 16) ? 32'd1 : 32'd0);
         cyc();
      end
      settle();
      chk_val("wd_edge16", 32'(Wait_timeout), 32'd1);
      chk_val("wd_stall",  32'(Stall_req),    32'd1);
      cyc(); RS_ready = 1'b1; settle();
      chk_val("wd_res_ctrl", 32'(NPC_ctrl),     32'd2);
      chk_val("wd_res_flag", 32'(Wait_timeout), 32'd1);
      cyc(); idle_in(); settle();
      chk_val("wd_sticky", 32'(Wait_timeout), 32'd1);

      // ---------------- WAIT abandoned by ID_valid drop ----------------
      cyc(); ID_valid = 1'b1; J_type = 2'd2; RS_ready = 1'b0; settle();
      chk_val("drop_wait_stall", 32'(Stall_req), 32'd1);
      cyc(); ID_valid = 1'b0; settle();
      chk_val("drop_stall", 32'(Stall_req), 32'd0);
      chk_val("drop_ctrl",  32'(NPC_ctrl),  32'd0);
      cyc(); idle_in();

      // ---------------- second control in HOLD, then reset mid-HOLD --------
      cyc();
      ID_valid = 1'b1; Br_type = 3'd1; J_type = 2'd0; PC_ID = 32'h0000_3000;
      Imm16 = 16'h0004; RS_val = 32'd5; RT_val = 32'd5; Fetch_stall = 1'b1;
      settle();
      chk_val("hb_res_ctrl", 32'(NPC_ctrl), 32'd1);
      cyc();
      Br_type = 3'd2; RT_val = 32'd6; PC_ID = 32'h0000_4000;
      settle();
      chk_val("hb_hold",  32'(Hold_active), 32'd1);
      chk_val("hb_stall", 32'(Stall_req),   32'd1);
      chk_val("hb_ctrl",  32'(NPC_ctrl),    32'd1);
      chk_val("hb_br",    BR,               32'h0000_3014);
      #1 reset = 1'b1;
      #1;
      chk_val("arst_ctrl",    32'(NPC_ctrl),     32'd0);
      chk_val("arst_stall",   32'(Stall_req),    32'd0);
      chk_val("arst_hold",    32'(Hold_active),  32'd0);
      chk_val("arst_timeout", 32'(Wait_timeout), 32'd0);
      chk_val("arst_br",      BR,                32'h0000_4014);
      #1 reset = 1'b0;
      Fetch_stall = 1'b0;
      #1;
      chk_val("post_bne_ctrl", 32'(NPC_ctrl),    32'd1);
      chk_val("post_bne_br",   BR,               32'h0000_4014);
      chk_val("post_bne_hold", 32'(Hold_active), 32'd0);
      cyc();
      Br_type = 3'd0; J_type = 2'd1; Index26 = 26'h000_0100;
      settle();
      chk_val("post_j_ctrl", 32'(NPC_ctrl), 32'd3);
      chk_val("post_j_tgt",  J_JAL,         32'h0000_0400);

      cyc(); idle_in();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_npc_ctrl_gen
`default_nettype wire
